fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Front end of the pipeline and the consumer of the execute-stage redirect (take_branch/flush/target PC).
//  Keeps the fetch PC and issues 16-bit Thumb instruction fetches to instruction memory.
//  Buffers responses in a small FIFO tagged with their PC and presents them to decode with a valid bit.
//  On a redirect it discards all buffered and in-flight fetches and restarts at the branch target.
// PARAMETERS
//  WORD          32            datapath/PC width (from GENERAL_DEFS)
//  FIFO_DEPTH    4             fetch buffer entries, power of two, >=2
//  RESET_VECTOR  32'h0000_0000 first fetch address after reset
// PORTS
//  clk_i             in   1      single clock, all state on posedge
//  reset_i           in   1      synchronous, active-high reset
//  take_branch_i     in   1      execute stage redirect request
//  flush_pipeline_i  in   1      execute stage flush; redirect = take_branch_i | flush_pipeline_i
//  branch_target_i   in   WORD   redirect address; bit 0 ignored (forced 0)
//  stall_i           in   1      decode cannot accept this cycle
//  imem_req_o        out  1      fetch request this cycle
//  imem_addr_o       out  WORD   fetch address (halfword aligned)
//  imem_valid_i      in   1      response valid; fixed 1-cycle latency after imem_req_o
//  imem_data_i       in   16     fetched halfword
//  instruction_o     out  16     instruction at FIFO head
//  program_counter_o out  WORD   address of instruction_o (not +4; execute adds the ARM offset)
//  is_valid_o        out  1      instruction_o/program_counter_o valid
// BEHAVIOUR
//  Reset (reset_i=1 at a posedge):
//   - fetch_pc=RESET_VECTOR; FIFO empty; inflight=0.
//   - is_valid_o=0, imem_req_o=0, instruction_o=0, program_counter_o=0.
//  State:
//   - fetch_pc; FIFO entries {pc,instr}; occupancy 0..FIFO_DEPTH.
//   - inflight (1 bit): request issued last cycle, response due this cycle.
//  Request: imem_req_o = !reset_i & !redirect & (occupancy + inflight < FIFO_DEPTH).
//   - The same-cycle pop is ignored (conservative credit).
//   - imem_addr_o=fetch_pc.
//   - On a request, fetch_pc <= fetch_pc + 2, mod 2^WORD (wraps 0xFFFF_FFFE -> 0).
//  Response: when imem_valid_i=1 and no redirect this cycle, push {pc of that request, imem_data_i}.
//   - The pc tag is held in a register captured at request time.
//   - A response never arrives to a full FIFO; bench asserts this.
//  Output: is_valid_o = !empty & !redirect. Head data comes from registers (no memory->decode bypass).
//  Pop: is_valid_o & !stall_i. Pop on empty is impossible by construction.
//   - Simultaneous push and pop leaves occupancy unchanged. Head advances, tail writes.
//  Redirect (highest priority, same cycle):
//   - Clear FIFO; drop any response arriving this cycle.
//   - No request this cycle; fetch_pc <= {branch_target_i[WORD-1:1],1'b0}; inflight <= 0.
//   - is_valid_o forced 0 combinationally this cycle.
//  Redirect timing (redirect in cycle t):
//   - t+1: request to target.
//   - t+2: response pushed.
//   - t+3: is_valid_o=1 with the target instruction.
//   - Penalty is 3 bubbles.
//  Back-to-back redirects: each restarts the sequence; the last one wins.
//  Redirect overrides stall_i. Redirect during reset is ignored.
//  After reset deasserts in cycle c: request RESET_VECTOR at c, valid out at c+2.
//  Steady state (no stall): one instruction per cycle. PCs increase by 2 with no gaps or duplicates.
//  stall_i held: FIFO fills to FIFO_DEPTH; requests stop once occupancy + inflight hits FIFO_DEPTH.
//   - Head stays stable (instruction_o/program_counter_o do not change while stalled).
//  No combinational path from imem_data_i to instruction_o.
//   - Redirect inputs reach is_valid_o and imem_req_o combinationally, by design.
// TESTING
//  Reset release, no stall, mem[0..6]=A,B,C,D -> is_valid_o from cycle 2; PCs 0,2,4,6 on consecutive cycles.
//  stall_i=1 for 10 cycles -> imem_req_o stops after 4 entries. Head holds PC 0 stable.
//   - Release -> PCs 0,2,4,6,8 with no loss or duplication.
//  take_branch_i with target 0x101 at cycle t, while 3 entries buffered and 1 in flight
//   -> old entries never valid; imem_addr_o=0x100 at t+1; PC 0x100 valid at t+3.
//  Redirects in t and t+1 (targets 0x40, 0x80) -> no 0x40 instruction emitted; first valid PC is 0x80 at t+4.
//  Redirect coincides with stall_i=1 and imem_valid_i=1 -> FIFO empty next cycle; stale response not pushed.
//  fetch_pc=0xFFFF_FFFC, no stall -> PCs 0xFFFF_FFFC, 0xFFFF_FFFE, 0x0; reset mid-stream -> outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Pipeline front end. It holds the fetch PC and issues one 16-bit Thumb
//   halfword fetch per cycle to instruction memory. Memory answers exactly one
//   cycle after a request. Each response is buffered in a small FIFO together
//   with the PC it was fetched from. The FIFO head is presented to decode with
//   a valid bit. An execute-stage redirect (take_branch_i | flush_pipeline_i)
//   discards every buffered and in-flight fetch and restarts fetch at the
//   branch target.
//
// Parameters
//   WORD          datapath / PC width
//   FIFO_DEPTH    fetch buffer entries (power of two, >= 2)
//   RESET_VECTOR  first fetch address after reset
//
// Ports
//   clk_i             in   clock, all state updates on posedge
//   reset_i           in   synchronous active-high reset
//   take_branch_i     in   execute-stage branch redirect
//   flush_pipeline_i  in   execute-stage flush (also a redirect)
//   branch_target_i   in   redirect address, bit 0 ignored
//   stall_i           in   decode cannot accept the head this cycle
//   imem_req_o        out  fetch request this cycle
//   imem_addr_o       out  fetch address (halfword aligned)
//   imem_valid_i      in   response valid, one cycle after imem_req_o
//   imem_data_i       in   fetched halfword
//   instruction_o     out  instruction at the FIFO head (0 when empty)
//   program_counter_o out  address of instruction_o (0 when empty)
//   is_valid_o        out  instruction_o / program_counter_o are valid
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              WORD         = 32,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [WORD-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            take_branch_i,
  input  logic            flush_pipeline_i,
  input  logic [WORD-1:0] branch_target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [WORD-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [15:0]     imem_data_i,
  output logic [15:0]     instruction_o,
  output logic [WORD-1:0] program_counter_o,
  output logic            is_valid_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Fetch-side state
  logic [WORD-1:0]  fetch_pc;
  logic [WORD-1:0]  req_pc;      // PC of the request whose response is due
  logic             inflight;

  // Fetch buffer
  logic [WORD-1:0]  pc_mem    [FIFO_DEPTH];
  logic [15:0]      instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             redirect;
  logic             empty;
  logic             credit_ok;
  logic             push;
  logic             pop;
  logic [WORD-1:0]  target_aligned;
  logic [CNT_W:0]   committed;

  assign redirect       = take_branch_i | flush_pipeline_i;
  assign empty          = (count == '0);
  // Masking bit 0 this way keeps every target bit in use.
  assign target_aligned = branch_target_i & ~WORD'(1);

  // Credit check counts the in-flight response but ignores a same-cycle pop,
  // so a response can never arrive at a full buffer.
  assign committed  = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign credit_ok  = committed < (CNT_W + 1)'(FIFO_DEPTH);

  assign imem_req_o  = !reset_i && !redirect && credit_ok;
  assign imem_addr_o = fetch_pc;

  // A redirect drops the response arriving in the same cycle.
  assign push = imem_valid_i && !redirect && !reset_i;

  // Redirect kills the head combinationally so decode never sees a stale
  // instruction in the redirect cycle, even while stalled.
  assign is_valid_o = !empty && !redirect;
  assign pop        = is_valid_o && !stall_i;

  assign instruction_o     = empty ? '0 : instr_mem[rd_ptr];
  assign program_counter_o = empty ? '0 : pc_mem[rd_ptr];

  // Control state: PC, in-flight tracking and FIFO pointers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc <= RESET_VECTOR;
      req_pc   <= RESET_VECTOR;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= target_aligned;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + WORD'(2);   // wraps modulo 2^WORD
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;            // idle, or push and pop together
      endcase
    end
  end

  // Buffer storage.
  // NOTE: storage is deliberately not reset; occupancy and pointers define
  // which entries are live, and the outputs read zero while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Inputs change on the falling edge and
//   outputs are checked 1 ns later. The instruction memory model answers every
//   request one cycle later with a halfword derived from the address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int FIFO_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        take_branch_i = 1'b0;
  logic        flush_pipeline_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i = 1'b0;
  logic [15:0] imem_data_i = '0;
  logic [15:0] instruction_o;
  logic [31:0] program_counter_o;
  logic        is_valid_o;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(
    .WORD(32), .FIFO_DEPTH(FIFO_DEPTH), .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .take_branch_i(take_branch_i), .flush_pipeline_i(flush_pipeline_i),
    .branch_target_i(branch_target_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
    .instruction_o(instruction_o), .program_counter_o(program_counter_o),
    .is_valid_o(is_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ 16'h5A3C;
  endfunction

  // Instruction memory: fixed one-cycle latency.
  always @(posedge clk_i) begin
    imem_valid_i <= imem_req_o;
    imem_data_i  <= mem_word(imem_addr_o);
  end

  // A response must never arrive at a full buffer.
  always @(posedge clk_i) begin
    if (!reset_i && imem_valid_i && !(take_branch_i || flush_pipeline_i)
        && dut.count == FIFO_DEPTH) begin
      $display("FAIL overflow: response arrived with buffer full at %0t", $time);
      miscompares++;
    end
  end

  // Apply one cycle of inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic rst, input logic br, input logic fl,
                       input logic [31:0] tgt, input logic stl);
    @(negedge clk_i);
    reset_i          = rst;
    take_branch_i    = br;
    flush_pipeline_i = fl;
    branch_target_i  = tgt;
    stall_i          = stl;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Expect a valid head with the given PC and matching memory data.
  task automatic expect_head(input string name, input logic [31:0] pc);
    vectors++;
    if (is_valid_o !== 1'b1 || program_counter_o !== pc ||
        instruction_o !== mem_word(pc)) begin
      $display("FAIL %s: got valid=%b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
               name, is_valid_o, program_counter_o, instruction_o, pc, mem_word(pc));
      miscompares++;
    end
  endtask

  task automatic expect_invalid(input string name);
    vectors++;
    if (is_valid_o !== 1'b0) begin
      $display("FAIL %s: got valid=%b pc=%h, want valid=0",
               name, is_valid_o, program_counter_o);
      miscompares++;
    end
  endtask

  task automatic expect_req(input string name, input logic req, input logic [31:0] addr);
    vectors++;
    if (imem_req_o !== req || (req && imem_addr_o !== addr)) begin
      $display("FAIL %s: got req=%b addr=%h, want req=%b addr=%h",
               name, imem_req_o, imem_addr_o, req, addr);
      miscompares++;
    end
  endtask

  task automatic expect_reset_outputs(input string name);
    vectors++;
    if (is_valid_o !== 1'b0 || imem_req_o !== 1'b0 ||
        instruction_o !== 16'h0 || program_counter_o !== 32'h0) begin
      $display("FAIL %s: got valid=%b req=%b instr=%h pc=%h, want all zero",
               name, is_valid_o, imem_req_o, instruction_o, program_counter_o);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    expect_reset_outputs("reset_state");
    // Redirect during reset is ignored: fetch still starts at the reset vector.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_req("reset_redirect_ignored", 1'b1, 32'h0000_0000);
  endtask

  task automatic test_steady();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // cycle c
    expect_req("steady_first_req", 1'b1, 32'h0);
    expect_invalid("steady_c0");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // c+1
    expect_invalid("steady_c1");
    for (int i = 0; i < 4; i++) begin                 // c+2 .. c+5
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      expect_head("steady_stream", 32'(2 * i));
    end
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (imem_req_o) reqs++;
      if (i >= 2) expect_head("stall_head_stable", 32'h0);
    end
    vectors++;
    if (reqs !== 4) begin
      $display("FAIL stall_req_count: got %0d requests, want 4", reqs);
      miscompares++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      expect_head("stall_release", 32'(2 * i));
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    // Three entries buffered and one in flight.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0101, 1'b0);    // t
    expect_invalid("redir_t");
    expect_req("redir_t_noreq", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+1
    expect_req("redir_t1_req", 1'b1, 32'h0000_0100);
    expect_invalid("redir_t1");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+2
    expect_invalid("redir_t2");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+3
    expect_head("redir_t3", 32'h0000_0100);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+4
    expect_head("redir_t4", 32'h0000_0102);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 1'b0);    // t
    expect_invalid("b2b_t");
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);    // t+1
    expect_invalid("b2b_t1");
    expect_req("b2b_t1_noreq", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+2
    expect_req("b2b_t2_req", 1'b1, 32'h0000_0080);
    expect_invalid("b2b_t2");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+3
    expect_invalid("b2b_t3");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+4
    expect_head("b2b_t4", 32'h0000_0080);
  endtask

  task automatic test_redirect_stall();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect while stalled, with a response arriving this same cycle.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b1);    // t
    vectors++;
    if (imem_valid_i !== 1'b1) begin
      $display("FAIL redir_stall_setup: got imem_valid=%b, want 1", imem_valid_i);
      miscompares++;
    end
    expect_invalid("redir_stall_t");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);            // t+1
    expect_invalid("redir_stall_empty");
    expect_req("redir_stall_req", 1'b1, 32'h0000_0200);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);            // t+2
    expect_invalid("redir_stall_t2");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);            // t+3
    expect_head("redir_stall_t3", 32'h0000_0200);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);            // t+4
    expect_head("redir_stall_hold", 32'h0000_0200);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);    // t
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+1
    expect_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+2
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);            // t+3
    expect_head("wrap_fffc", 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_head("wrap_fffe", 32'hFFFF_FFFE);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_head("wrap_zero", 32'h0000_0000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);            // reset mid-stream
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_reset_outputs("midstream_reset");
  endtask

  initial begin
    test_reset();
    test_steady();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_redirect_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
